// File: rtl/bin_to_dspl_enc.sv
// ---------------------------------------------------------------------------
// bin_to_dspl_enc
//
// Purpose
//   Converts an unsigned binary value into eight 6-bit digit codes d1..d8 for
//   the 8-digit multiplexed 7-segment display driver.
//   - d1 is the units (rightmost) digit and d8 is the leftmost digit.
//   - The conversion is a sequential double-dabble: one shift per clock.
//   - Values above MAX_VALUE saturate to all nines and raise overflow.
//
// Digit code
//   [5]   digit lit (1 = on)
//   [4:1] BCD value 0..9
//   [0]   reserved, always 0
//
// Optional feature (macro LZ_BLANK_EN)
//   When LZ_BLANK_EN is defined, leading zeros on d2..d8 are blanked to 6'h00.
//   d1 is always lit. Without the macro, all eight digits are lit.
//
// Parameters
//   IN_WIDTH   width of value, legal range 1..27
//   MAX_VALUE  saturation limit (8 decimal digits)
//
// Ports
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   conversion request, sampled only while idle
//   value      in   operand, captured on the accepted start edge
//   busy       out  conversion in progress
//   done       out  one-cycle pulse: d1..d8 and overflow were just updated
//   overflow   out  last accepted value exceeded MAX_VALUE
//   d1..d8     out  digit codes
//   state_dbg  out  current FSM state (0 = IDLE, 1 = SHIFT)
//
// Handshake
//   A start seen high at a rising edge while idle is accepted at that edge.
//   busy rises immediately after that edge. A start seen while busy is
//   dropped, not queued. After exactly IN_WIDTH shift edges, the results are
//   registered, done pulses for one cycle and busy falls. A new start can be
//   accepted on the very next edge. d1..d8 and overflow only change on the
//   edge that raises done, so the display never shows a partial result.
// ---------------------------------------------------------------------------
module bin_to_dspl_enc #(
  parameter int          IN_WIDTH  = 27,
  parameter int unsigned MAX_VALUE = 99_999_999
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] value,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [5:0]          d1,
  output logic [5:0]          d2,
  output logic [5:0]          d3,
  output logic [5:0]          d4,
  output logic [5:0]          d5,
  output logic [5:0]          d6,
  output logic [5:0]          d7,
  output logic [5:0]          d8,
  output logic                state_dbg
);

  localparam int                 CNT_W     = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(IN_WIDTH);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [31:0]        MAX32     = 32'(MAX_VALUE);
  // Only reachable when an over-limit value is possible, in which case
  // MAX_VALUE fits in IN_WIDTH bits and the truncation is lossless.
  localparam logic [IN_WIDTH-1:0] MAX_TRUNC = IN_WIDTH'(MAX_VALUE);
  localparam logic [5:0]         DIG_ZERO  = 6'h20;

`ifdef LZ_BLANK_EN
  localparam logic [5:0] LEAD_RST = 6'h00;
`else
  localparam logic [5:0] LEAD_RST = 6'h20;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state;
  logic [IN_WIDTH-1:0]   bin_q;
  logic [31:0]           bcd_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  sat_q;
  logic [5:0]            dig_q [8];

  logic                  value_over;
  logic [IN_WIDTH-1:0]   captured;
  logic [31:0]           bcd_adj;
  logic [31+IN_WIDTH:0]  shifted;
  logic [31:0]           bcd_next;
  logic [IN_WIDTH-1:0]   bin_next;
  logic [5:0]            dig_next [8];

  // Add 3 to every nibble that is 5 or more, so that the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [31:0] dabble_adjust(input logic [31:0] bcd);
    logic [31:0] r;
    r = bcd;
    for (int n = 0; n < 8; n++) begin
      if (bcd[4*n +: 4] >= 4'd5) begin
        r[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // If 2**IN_WIDTH-1 <= MAX_VALUE, this comparison folds to constant false.
  always_comb begin
    value_over = (32'(value) > MAX32);
    captured   = value_over ? MAX_TRUNC : value;
  end

  // One double-dabble step on the combined {bcd, bin} register.
  always_comb begin
    bcd_adj  = dabble_adjust(bcd_q);
    shifted  = {bcd_adj, bin_q} << 1;
    bcd_next = shifted[31+IN_WIDTH:IN_WIDTH];
    bin_next = shifted[IN_WIDTH-1:0];
  end

  // Digit codes built from the BCD value after the final shift. These are
  // only registered on the last SHIFT edge.
`ifdef LZ_BLANK_EN
  // Scan from the most significant digit downwards. A digit is blanked while
  // it and every digit above it are zero. d1 is always lit.
  always_comb begin
    logic       lead;
    logic [3:0] nib;
    lead = 1'b1;
    nib  = 4'd0;
    for (int k = 7; k >= 1; k--) begin
      nib  = bcd_next[4*k +: 4];
      lead = lead & (nib == 4'd0);
      dig_next[k] = lead ? 6'h00 : {1'b1, nib, 1'b0};
    end
    dig_next[0] = {1'b1, bcd_next[3:0], 1'b0};
  end
`else
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      dig_next[k] = {1'b1, bcd_next[4*k +: 4], 1'b0};
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      dig_q[0] <= DIG_ZERO;
      for (int k = 1; k < 8; k++) begin
        dig_q[k] <= LEAD_RST;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_q <= captured;
            bcd_q <= '0;
            cnt_q <= CNT_LOAD;
            sat_q <= value_over;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bin_q <= bin_next;
          bcd_q <= bcd_next;
          cnt_q <= cnt_q - CNT_ONE;
          // Last shift: publish the result in the same edge.
          if (cnt_q == CNT_ONE) begin
            for (int k = 0; k < 8; k++) begin
              dig_q[k] <= dig_next[k];
            end
            overflow <= sat_q;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

  assign d1        = dig_q[0];
  assign d2        = dig_q[1];
  assign d3        = dig_q[2];
  assign d4        = dig_q[3];
  assign d5        = dig_q[4];
  assign d6        = dig_q[5];
  assign d7        = dig_q[6];
  assign d8        = dig_q[7];
  assign state_dbg = state;

endmodule

// File: tb/tb_bin_to_dspl_enc.sv
// ---------------------------------------------------------------------------
// tb_bin_to_dspl_enc
//
// Directed bench for bin_to_dspl_enc with IN_WIDTH = 27.
// Expected results are hand-written digit codes, packed as
// {overflow, d8, ..., d1}. Results that contain leading zeros follow the
// LZ_BLANK_EN build option through LZ.
// ---------------------------------------------------------------------------
module tb_bin_to_dspl_enc;

  localparam int W = 49;

`ifdef LZ_BLANK_EN
  localparam logic [5:0] LZ = 6'h00;
`else
  localparam logic [5:0] LZ = 6'h20;
`endif

  // -------------------------------------------------------------------------
  // Clock and reset
  // -------------------------------------------------------------------------
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [26:0] value = '0;
  logic        busy, done, overflow, state_dbg;
  logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;
  logic [47:0] dout;

  always #5 clock = ~clock;

  assign dout = {d8, d7, d6, d5, d4, d3, d2, d1};

  bin_to_dspl_enc #(.IN_WIDTH(27), .MAX_VALUE(99_999_999)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .value     (value),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .d4        (d4),
    .d5        (d5),
    .d6        (d6),
    .d7        (d7),
    .d8        (d8),
    .state_dbg (state_dbg)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           n_vec  = 0;
  int           n_miss = 0;
  int           code_err = 0;

  // Continuous monitor: the reserved bit must be 0 and the BCD field must be
  // at most 9 on every digit.
  always @(negedge clock) begin
    for (int k = 0; k < 8; k++) begin
      if (dout[6*k] !== 1'b0 || dout[6*k+1 +: 4] > 4'd9) code_err++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------

  // Call just after an accepted start edge. Counts the busy cycles and waits,
  // with a bound, for done. Also checks that the outputs hold their previous
  // value until done is raised.
  task automatic wait_done(input string tag, output int lat, output int busy_cnt);
    logic [W-1:0] prev;
    int           hold_err;
    prev     = {overflow, dout};
    hold_err = 0;
    lat      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) busy_cnt++;
      if ({overflow, dout} !== prev) hold_err++;
      value = 27'($urandom_range(0, 27'h7FF_FFFF));
      @(posedge clock); #1;
      lat++;
    end
    check({tag, " hold"}, 64'(hold_err), 64'd0);
  endtask

  // Single conversion: pulse start for one cycle, then check latency, busy
  // time, the result and the single-cycle width of done.
  task automatic convert(input string tag, input logic [26:0] v, input logic [W-1:0] exp);
    int lat, bc;
    value = v;
    start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(tag, lat, bc);
    check({tag, " latency"}, 64'(lat), 64'd27);
    check({tag, " busy_cycles"}, 64'(bc), 64'd27);
    check({tag, " result"}, 64'({overflow, dout}), 64'(exp_q.pop_front()));
    @(posedge clock); #1;
    check({tag, " done_width"}, 64'({done, busy}), 64'd0);
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int lat, bc, dcnt;

    // Reset values.
    #12;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst overflow", 64'(overflow), 64'd0);
    check("rst digits", 64'(dout), 64'({LZ, LZ, LZ, LZ, LZ, LZ, LZ, 6'h20}));
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Main function.
    convert("v12345678", 27'd12_345_678,
            {1'b0, 6'h22, 6'h24, 6'h26, 6'h28, 6'h2A, 6'h2C, 6'h2E, 6'h30});
    convert("v405", 27'd405,
            {1'b0, LZ, LZ, LZ, LZ, LZ, 6'h28, 6'h20, 6'h2A});
    convert("v0", 27'd0,
            {1'b0, LZ, LZ, LZ, LZ, LZ, LZ, LZ, 6'h20});
    convert("v1000005", 27'd1_000_005,
            {1'b0, LZ, 6'h22, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h2A});
    convert("vmax", 27'd99_999_999,
            {1'b0, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32});
    convert("vmax_p1", 27'd100_000_000,
            {1'b1, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32});
    convert("v9", 27'd9,
            {1'b0, LZ, LZ, LZ, LZ, LZ, LZ, LZ, 6'h32});
    convert("vall1", 27'h7FF_FFFF,
            {1'b1, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32});

    // start held high: one conversion per 28 clocks, each using the value
    // present at its own accepted start edge.
    value = 27'd87_654_321;
    start = 1'b1;
    @(posedge clock); #1;
    value = 27'd405;
    wait_done("b2b_a", lat, bc);
    check("b2b_a latency", 64'(lat), 64'd27);
    check("b2b_a result", 64'({overflow, dout}),
          64'({1'b0, 6'h30, 6'h2E, 6'h2C, 6'h2A, 6'h28, 6'h26, 6'h24, 6'h22}));
    value = 27'd55;
    @(posedge clock); #1;
    check("b2b done_width", 64'(done), 64'd0);
    check("b2b rearm busy", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done("b2b_b", lat, bc);
    check("b2b_b latency", 64'(lat), 64'd27);
    check("b2b_b result", 64'({overflow, dout}),
          64'({1'b0, LZ, LZ, LZ, LZ, LZ, LZ, 6'h2A, 6'h2A}));
    @(posedge clock); #1;

    // Reset asserted on the 10th SHIFT cycle. The previous result has
    // overflow set, so the reset values differ from the current outputs.
    convert("pre_abort", 27'd120_000_000,
            {1'b1, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32, 6'h32});
    value = 27'd777;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort overflow", 64'(overflow), 64'd0);
    check("abort digits", 64'(dout), 64'({LZ, LZ, LZ, LZ, LZ, LZ, LZ, 6'h20}));
    @(posedge clock); #1;
    reset_n = 1'b1;
    dcnt = 0;
    repeat (35) begin
      @(posedge clock); #1;
      if (done === 1'b1) dcnt++;
    end
    check("abort no_done", 64'(dcnt), 64'd0);
    convert("post_abort", 27'd405,
            {1'b0, LZ, LZ, LZ, LZ, LZ, 6'h28, 6'h20, 6'h2A});

    check("digit codes legal", 64'(code_err), 64'd0);
    check("scoreboard empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
